// File: rtl/axi_rd_arbiter.sv
// Round-robin merge of NUM_MST internal read requesters onto one AXI AR/R port.
// One burst in flight; R beats are steered back to the granted master and checked for id/length errors.
module axi_rd_arbiter #(
  parameter int NUM_MST = 3,
  parameter int DATA_W  = 32,
  parameter int ID_W    = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_MST-1:0]   m_arvalid,
  input  logic [NUM_MST*32-1:0] m_araddr,
  input  logic [NUM_MST*8-1:0] m_arlen,
  input  logic [NUM_MST*3-1:0] m_arsize,
  output logic [NUM_MST-1:0]   m_arready,
  output logic [NUM_MST-1:0]   m_rvalid,
  output logic [DATA_W-1:0]    m_rdata,
  output logic [1:0]           m_rresp,
  output logic                 m_rlast,
  input  logic [NUM_MST-1:0]   m_rready,
  output logic [ID_W-1:0]      arid,
  output logic [31:0]          araddr,
  output logic [7:0]           arlen,
  output logic [2:0]           arsize,
  output logic [1:0]           arburst,
  output logic                 arvalid,
  input  logic                 arready,
  input  logic [ID_W-1:0]      rid,
  input  logic [DATA_W-1:0]    rdata,
  input  logic [1:0]           rresp,
  input  logic                 rlast,
  input  logic                 rvalid,
  output logic                 rready,
  output logic                 proto_err
);

  localparam int IDX_W = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

  state_t           state_reg;
  logic [IDX_W-1:0] ptr_reg;
  logic [IDX_W-1:0] grant_reg;
  logic [7:0]       beat_cnt_reg;
  logic             proto_err_reg;
  logic [31:0]      araddr_reg;
  logic [7:0]       arlen_reg;
  logic [2:0]       arsize_reg;

  logic [31:0]      addr_arr [NUM_MST];
  logic [7:0]       len_arr  [NUM_MST];
  logic [2:0]       size_arr [NUM_MST];

  logic [NUM_MST-1:0] upper_mask;
  logic [NUM_MST-1:0] req_upper;
  logic [IDX_W-1:0]   pick_lo;
  logic [IDX_W-1:0]   pick_hi;
  logic [IDX_W-1:0]   pick;
  logic               req_any;
  logic               grant_ok;
  logic               beat;
  logic               rid_bad;
  logic               len_bad;
  logic               last_wrap;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MST; gi++) begin : g_mst
      assign addr_arr[gi]   = m_araddr[32*gi +: 32];
      assign len_arr[gi]    = m_arlen[8*gi +: 8];
      assign size_arr[gi]   = m_arsize[3*gi +: 3];
      // Requesters at or above the pointer win first; the rest are the wrapped tail.
      assign upper_mask[gi] = (IDX_W'(gi) >= ptr_reg);
      assign m_arready[gi]  = grant_ok && (pick == IDX_W'(gi));
      assign m_rvalid[gi]   = (state_reg == S_DATA) && rvalid && (grant_reg == IDX_W'(gi));
    end
  endgenerate

  assign req_upper = m_arvalid & upper_mask;
  assign req_any   = |m_arvalid;

  always_comb begin
    pick_lo = '0;
    pick_hi = '0;
    for (int k = NUM_MST - 1; k >= 0; k--) begin
      if (m_arvalid[k]) pick_lo = IDX_W'(k);
      if (req_upper[k]) pick_hi = IDX_W'(k);
    end
  end

  assign pick     = (|req_upper) ? pick_hi : pick_lo;
  assign grant_ok = (state_reg == S_IDLE) && req_any && !reset;

  assign arvalid   = (state_reg == S_ADDR);
  assign arid      = ID_W'(grant_reg);
  assign araddr    = araddr_reg;
  assign arlen     = arlen_reg;
  assign arsize    = arsize_reg;
  assign arburst   = 2'b01;
  assign rready    = (state_reg == S_DATA) && m_rready[grant_reg];
  assign m_rdata   = rdata;
  assign m_rresp   = rresp;
  assign m_rlast   = rlast;
  assign proto_err = proto_err_reg;

  assign beat      = (state_reg == S_DATA) && rvalid && rready;
  assign rid_bad   = (rid != ID_W'(grant_reg));
  // Early rlast and missing rlast are both length errors.
  assign len_bad   = rlast ? (beat_cnt_reg != arlen_reg) : (beat_cnt_reg == arlen_reg);
  assign last_wrap = (grant_reg == IDX_W'(NUM_MST - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      ptr_reg       <= '0;
      grant_reg     <= '0;
      beat_cnt_reg  <= '0;
      proto_err_reg <= 1'b0;
      araddr_reg    <= '0;
      arlen_reg     <= '0;
      arsize_reg    <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (req_any) begin
            grant_reg  <= pick;
            araddr_reg <= addr_arr[pick];
            arlen_reg  <= len_arr[pick];
            arsize_reg <= size_arr[pick];
            state_reg  <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (arready) begin
            beat_cnt_reg <= '0;
            state_reg    <= S_DATA;
          end
        end
        S_DATA: begin
          if (beat) begin
            beat_cnt_reg <= beat_cnt_reg + 8'd1;
            if (rid_bad || len_bad) proto_err_reg <= 1'b1;
            if (rlast) begin
              state_reg <= S_IDLE;
              ptr_reg   <= last_wrap ? '0 : grant_reg + IDX_W'(1);
            end
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: the bench acts as every master and as the AXI slave,
// with scoreboard queues holding expected AR requests and R beats.
module tb_axi_rd_arbiter;
  localparam int NUM_MST = 3;
  localparam int DATA_W  = 32;
  localparam int ID_W    = 4;

  logic                  clock = 1'b0;
  logic                  reset;
  logic [NUM_MST-1:0]    m_arvalid;
  logic [NUM_MST*32-1:0] m_araddr;
  logic [NUM_MST*8-1:0]  m_arlen;
  logic [NUM_MST*3-1:0]  m_arsize;
  logic [NUM_MST-1:0]    m_arready;
  logic [NUM_MST-1:0]    m_rvalid;
  logic [DATA_W-1:0]     m_rdata;
  logic [1:0]            m_rresp;
  logic                  m_rlast;
  logic [NUM_MST-1:0]    m_rready;
  logic [ID_W-1:0]       arid;
  logic [31:0]           araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arvalid;
  logic                  arready;
  logic [ID_W-1:0]       rid;
  logic [DATA_W-1:0]     rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;
  logic                  proto_err;

  always #5 clock = ~clock;

  axi_rd_arbiter #(.NUM_MST(NUM_MST), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .clock(clock), .reset(reset),
    .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arready(m_arready), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rlast(m_rlast), .m_rready(m_rready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .proto_err(proto_err)
  );

  typedef struct {
    int          g;
    logic [31:0] addr;
    logic [7:0]  len;
  } ar_t;

  ar_t                 ar_q[$];
  logic [DATA_W+2:0]   beat_q[$];
  int                  checks = 0;
  int                  errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int g, input logic [31:0] addr, input logic [7:0] len);
    ar_t e;
    m_araddr[32*g +: 32] = addr;
    m_arlen[8*g +: 8]    = len;
    m_arsize[3*g +: 3]   = 3'd2;
    m_arvalid[g]         = 1'b1;
    e.g = g; e.addr = addr; e.len = len;
    ar_q.push_back(e);
    #1;
  endtask

  // Runs one burst from the IDLE cycle in which master g should be granted.
  task automatic run_burst(input int g, input int nbeats, input int ar_wait,
                           input int stall_beat, input bit bad_rid, input bit hold);
    ar_t               e;
    logic [DATA_W-1:0] d;
    logic [DATA_W+2:0] exp_beat;
    check($sformatf("m_arready_grant%0d", g), m_arready, 64'(1 << g));
    step();
    if (!hold) m_arvalid[g] = 1'b0;
    #1;
    e = ar_q[0];
    for (int w = 0; w < ar_wait; w++) begin
      check("arvalid_wait", arvalid, 1);
      check("m_arready_wait", m_arready, 0);
      check("araddr_stable", araddr, e.addr);
      step();
    end
    arready = 1'b1;
    #1;
    e = ar_q.pop_front();
    check("arvalid", arvalid, 1);
    check("arid", arid, e.g);
    check("araddr", araddr, e.addr);
    check("arlen", arlen, e.len);
    check("arsize_arburst", {arsize, arburst}, {3'd2, 2'b01});
    $display("AR  grant=%0d arid=%0d araddr=%08h arlen=%0d", e.g, arid, araddr, arlen);
    step();
    arready = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      d      = $urandom;
      rdata  = d;
      rresp  = 2'(b);
      rlast  = (b == nbeats - 1);
      rid    = bad_rid ? 4'hF : ID_W'(g);
      rvalid = 1'b1;
      beat_q.push_back({rresp, rlast, d});
      if (b == stall_beat) begin
        m_rready = '0;
        for (int s = 0; s < 2; s++) begin
          #1;
          check("rready_stall", rready, 0);
          check("m_rvalid_stall", m_rvalid, 64'(1 << g));
          check("m_rdata_stall", m_rdata, d);
          step();
        end
        m_rready = '1;
      end
      #1;
      check("rready", rready, 1);
      check("m_rvalid", m_rvalid, 64'(1 << g));
      exp_beat = beat_q.pop_front();
      check("m_beat", {m_rresp, m_rlast, m_rdata}, exp_beat);
      $display("R   master=%0d beat=%0d data=%08h last=%0b", g, b, m_rdata, m_rlast);
      step();
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    #1;
  endtask

  initial begin
    ar_t e;
    reset = 1'b1; m_arvalid = '0; m_araddr = '0; m_arlen = '0; m_arsize = '0;
    m_rready = '1; arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
    step(); step();
    check("rst_arvalid", arvalid, 0);
    check("rst_rready", rready, 0);
    check("rst_m_arready", m_arready, 0);
    check("rst_m_rvalid", m_rvalid, 0);
    check("rst_proto_err", proto_err, 0);
    check("rst_arid", arid, 0);
    reset = 1'b0;
    step();

    // Single 4-beat burst from master 0.
    set_req(0, 32'h1C00_0000, 8'd3);
    run_burst(0, 4, 0, -1, 1'b0, 1'b0);
    check("t1_proto_err", proto_err, 0);
    step(); step();
    check("idle_m_arready", m_arready, 0);
    check("idle_arvalid", arvalid, 0);

    // arready held off; request held and re-granted as lone requester.
    set_req(2, 32'h2000_0040, 8'd0);
    run_burst(2, 1, 5, -1, 1'b0, 1'b1);
    set_req(2, 32'h2000_0080, 8'd1);
    run_burst(2, 2, 0, -1, 1'b0, 1'b0);

    // All three held: round-robin order 0,1,2.
    set_req(0, 32'h3000_0000, 8'd0);
    set_req(1, 32'h3000_1000, 8'd0);
    set_req(2, 32'h3000_2000, 8'd0);
    run_burst(0, 1, 0, -1, 1'b0, 1'b1);
    run_burst(1, 1, 0, -1, 1'b0, 1'b1);
    run_burst(2, 1, 0, -1, 1'b0, 1'b1);
    m_arvalid = '0;
    step();

    // Master stalls two cycles mid-burst.
    set_req(1, 32'h4000_0000, 8'd3);
    run_burst(1, 4, 0, 1, 1'b0, 1'b0);
    check("t4_proto_err", proto_err, 0);

    // Early rlast sets sticky error; following burst still completes.
    set_req(0, 32'h5000_0000, 8'd3);
    run_burst(0, 2, 0, -1, 1'b0, 1'b0);
    check("t5_proto_err", proto_err, 1);
    set_req(2, 32'h5000_1000, 8'd1);
    run_burst(2, 2, 0, -1, 1'b0, 1'b0);
    check("t5_proto_err_sticky", proto_err, 1);

    // Reset in DATA after one beat.
    set_req(1, 32'h6000_0000, 8'd3);
    check("t6_m_arready", m_arready, 3'b010);
    step();
    m_arvalid = '0;
    arready = 1'b1;
    #1;
    e = ar_q.pop_front();
    check("t6_arid", arid, e.g);
    step();
    arready = 1'b0; rvalid = 1'b1; rid = 4'd1; rdata = 32'hDEAD_BEEF; rlast = 1'b0;
    #1;
    check("t6_rready", rready, 1);
    step();
    reset = 1'b1; rvalid = 1'b0;
    step();
    check("t6_arvalid", arvalid, 0);
    check("t6_rready_rst", rready, 0);
    check("t6_proto_err", proto_err, 0);
    $display("RST mid-burst arvalid=%0b rready=%0b proto_err=%0b", arvalid, rready, proto_err);
    reset = 1'b0;
    step();

    // Pointer back at 0; then a bad rid flags an error.
    set_req(0, 32'h7000_0000, 8'd1);
    set_req(1, 32'h7000_1000, 8'd0);
    run_burst(0, 2, 0, -1, 1'b0, 1'b0);
    check("t7_proto_err", proto_err, 0);
    run_burst(1, 1, 0, -1, 1'b1, 1'b0);
    check("t7_rid_err", proto_err, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
